// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts one
// command byte out on device clock edges and reports ack, nack or timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // FINISH is the status-pulse cycle; keeping it out of IDLE means tx_ready
  // only rises once the pulse has gone.
  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE, S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       data_sync_q, data_sync_d;
  logic [9:0]       frame_q, frame_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             nack_q, nack_d;
  logic             done_q, done_d;
  logic             ack_err_q, ack_err_d;
  logic             timeout_q, timeout_d;

  logic clk_fall;
  logic lines_idle;

  assign clk_fall   = clk_sync_q[2] & ~clk_sync_q[1];
  assign lines_idle = clk_sync_q[1] & data_sync_q[1];

  always_comb begin
    state_d     = state_q;
    clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    frame_d     = frame_q;
    bit_cnt_d   = bit_cnt_q;
    cnt_d       = cnt_q;
    clk_oe_d    = clk_oe_q;
    data_oe_d   = data_oe_q;
    nack_d      = nack_q;
    done_d      = 1'b0;
    ack_err_d   = 1'b0;
    timeout_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          frame_d  = {1'b1, ~^tx_data, tx_data};
          cnt_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = S_REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_REQ: begin
        clk_oe_d  = 1'b0;
        cnt_d     = '0;
        bit_cnt_d = '0;
        state_d   = S_SEND;
      end

      S_SEND, S_ACK, S_WAIT_IDLE: begin
        if (cnt_q == TIMEOUT_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          cnt_d = cnt_q + 1'b1;
          case (state_q)
            S_SEND: begin
              if (clk_fall) begin
                data_oe_d = ~frame_q[0];
                frame_d   = {1'b0, frame_q[9:1]};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == 4'd9) begin
                  data_oe_d = 1'b0;
                  state_d   = S_ACK;
                end
              end
            end
            S_ACK: begin
              if (clk_fall) begin
                nack_d  = data_sync_q[1];
                state_d = S_WAIT_IDLE;
              end
            end
            default: begin
              if (lines_idle) begin
                done_d    = ~nack_q;
                ack_err_d = nack_q;
                state_d   = S_FINISH;
              end
            end
          endcase
        end
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      frame_q     <= '0;
      bit_cnt_q   <= '0;
      cnt_q       <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      nack_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      frame_q     <= frame_d;
      bit_cnt_q   <= bit_cnt_d;
      cnt_q       <= cnt_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      nack_q      <= nack_d;
      done_q      <= done_d;
      ack_err_q   <= ack_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and
// checks bits, status pulses and timing against a byte-level frame model.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 2000;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  wire        tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout;
  wire        ps2_clk, ps2_data;

  // Open-drain bus: either side may pull a line low.
  assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
    .done(done), .ack_err(ack_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int cyc = 0, done_n = 0, err_n = 0, to_n = 0;
  int oe_run = 0, last_oe_run = 0, req_cyc = 0, pulse_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (done === 1'b1) done_n++;
    if (ack_err === 1'b1) err_n++;
    if (timeout === 1'b1) to_n++;
    if ((done | ack_err | timeout) === 1'b1) pulse_cyc = cyc;
    if ((ps2_clk_oe & ps2_data_oe) === 1'b1) req_cyc = cyc;
    if (ps2_clk_oe === 1'b1) oe_run++;
    else if (oe_run != 0) begin
      last_oe_run = oe_run;
      oe_run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected on-wire frame as the device sees it: start, d0..d7, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = (b >> i) & 8'h01;
    f[9]  = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic start_tx(input logic [7:0] b, input bit hold);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (tx_ready === 1'b1) ok = 1'b1;
      else tick();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL start_ready: tx_ready=%b required=1 within 100 cycles", tx_ready);
    end
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    if (!hold) tx_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || tx_ready !== 1'b0) begin
      bad++;
      $display("FAIL accept: busy=%b tx_ready=%b required busy=1 tx_ready=0", busy, tx_ready);
    end
  endtask

  // Device model: mode 0 acks, mode 1 leaves data high on the 11th clock.
  // abort_at>0 returns with the clock held low during that bit.
  task automatic device(input int mode, input int abort_at, output logic [10:0] got);
    bit seen = 1'b0;
    got = '1;
    for (int i = 0; i < INH + 50 && !seen; i++) begin
      tick();
      if (ps2_clk === 1'b1 && ps2_data === 1'b0) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL rts_seen: request-to-send not observed within %0d cycles", INH + 50);
      return;
    end
    got[0] = ps2_data;
    repeat (5) tick();
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (20) tick();
      if (k == abort_at) return;
      dev_clk_low = 1'b0;
      tick();
      got[k] = ps2_data;
      repeat (19) tick();
    end
    if (mode == 0) dev_data_low = 1'b1;
    repeat (10) tick();
    dev_clk_low = 1'b1;
    repeat (20) tick();
    dev_clk_low = 1'b0;
    repeat (5) tick();
    dev_data_low = 1'b0;
  endtask

  // mode 2: no device clocking at all.
  task automatic run_frame(input logic [7:0] b, input int mode, input bit hold,
                           output logic [10:0] got, output int d_done, output int d_err,
                           output int d_to, output logic ready_pulse, output logic ready_next,
                           output logic oe_pulse);
    int  b_done, b_err, b_to;
    bit  hit = 1'b0;
    b_done = done_n; b_err = err_n; b_to = to_n;
    ready_pulse = 1'bx; ready_next = 1'bx; oe_pulse = 1'bx;
    got = '1;
    start_tx(b, hold);
    if (mode != 2) device(mode, 0, got);
    for (int i = 0; i < TMO + 500 && !hit; i++) begin
      if ((done | ack_err | timeout) === 1'b1) begin
        tx_valid    = 1'b0;
        ready_pulse = tx_ready;
        oe_pulse    = ps2_clk_oe | ps2_data_oe;
        tick();
        ready_next  = tx_ready;
        hit = 1'b1;
      end else if (done_n != b_done || err_n != b_err || to_n != b_to) begin
        hit = 1'b1;
      end else begin
        tick();
      end
    end
    tx_valid = 1'b0;
    tick();
    d_done = done_n - b_done;
    d_err  = err_n - b_err;
    d_to   = to_n - b_to;
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL status_wait: no done/ack_err/timeout within %0d cycles", TMO + 500);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    total++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
      bad++;
      $display("FAIL reset_oe: clk_oe=%b data_oe=%b required 0 0", ps2_clk_oe, ps2_data_oe);
    end
    total++;
    if ({busy, done, ack_err, timeout} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_status: busy/done/ack_err/timeout=%b required 0000",
               {busy, done, ack_err, timeout});
    end
    resetn = 1'b1;
    tick();
    total++;
    if (tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: tx_ready=%b required 1", tx_ready);
    end
  endtask

  task automatic check_frame(input string name, input logic [7:0] b, input int mode);
    logic [10:0] got;
    int d_done, d_err, d_to;
    logic rp, rn, op;
    run_frame(b, mode, 1'b0, got, d_done, d_err, d_to, rp, rn, op);
    total++;
    if (got !== model_frame(b)) begin
      bad++;
      $display("FAIL %s_bits: byte %02h frame=%011b required %011b", name, b, got, model_frame(b));
    end
    total++;
    if (d_done != (mode == 0 ? 1 : 0) || d_err != (mode == 1 ? 1 : 0) || d_to != 0) begin
      bad++;
      $display("FAIL %s_status: done=%0d ack_err=%0d timeout=%0d required %0d %0d 0",
               name, d_done, d_err, d_to, (mode == 0 ? 1 : 0), (mode == 1 ? 1 : 0));
    end
    $display("frame %s byte=%02h mode=%0d bits=%011b done=%0d ack_err=%0d", name, b, mode, got,
             d_done, d_err);
  endtask

  task automatic test_ack();
    check_frame("ack_ed", 8'hED, 0);
    total++;
    if (last_oe_run != INH + 1) begin
      bad++;
      $display("FAIL inhibit_len: clk_oe high %0d cycles required %0d", last_oe_run, INH + 1);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL ack_busy: busy=%b required 0", busy);
    end
  endtask

  task automatic test_nack();
    check_frame("nack_f4", 8'hF4, 1);
  endtask

  task automatic test_timeout();
    logic [10:0] got;
    int d_done, d_err, d_to;
    logic rp, rn, op;
    run_frame(8'h00, 2, 1'b0, got, d_done, d_err, d_to, rp, rn, op);
    total++;
    if (d_to != 1 || d_done != 0 || d_err != 0) begin
      bad++;
      $display("FAIL timeout_status: timeout=%0d done=%0d ack_err=%0d required 1 0 0",
               d_to, d_done, d_err);
    end
    total++;
    if (pulse_cyc - req_cyc < TMO - 5 || pulse_cyc - req_cyc > TMO + 5) begin
      bad++;
      $display("FAIL timeout_delay: %0d cycles after REQ required %0d +/-5",
               pulse_cyc - req_cyc, TMO);
    end
    total++;
    if (op !== 1'b0 || rn !== 1'b1) begin
      bad++;
      $display("FAIL timeout_release: oe_any=%b ready_next=%b required 0 1", op, rn);
    end
    $display("timeout byte=00 delay=%0d", pulse_cyc - req_cyc);
  endtask

  task automatic test_reset_mid();
    logic [10:0] got;
    int b_all;
    start_tx(8'hA5, 1'b0);
    device(0, 5, got);
    resetn = 1'b0;
    tick();
    total++;
    if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
      bad++;
      $display("FAIL midreset_release: clk_oe/data_oe/busy=%b required 000",
               {ps2_clk_oe, ps2_data_oe, busy});
    end
    resetn = 1'b1;
    dev_clk_low = 1'b0;
    b_all = done_n + err_n + to_n;
    repeat (100) tick();
    total++;
    if (done_n + err_n + to_n != b_all) begin
      bad++;
      $display("FAIL midreset_pulse: %0d status pulses required 0", done_n + err_n + to_n - b_all);
    end
    check_frame("after_reset_a5", 8'hA5, 0);
  endtask

  task automatic test_hold_valid();
    logic [10:0] got;
    int d_done, d_err, d_to, b_done;
    logic rp, rn, op;
    run_frame(8'hED, 0, 1'b1, got, d_done, d_err, d_to, rp, rn, op);
    b_done = done_n;
    repeat (60) tick();
    total++;
    if (d_done != 1 || done_n != b_done || busy !== 1'b0) begin
      bad++;
      $display("FAIL hold_valid: done=%0d extra=%0d busy=%b required 1 0 0",
               d_done, done_n - b_done, busy);
    end
    $display("hold_valid byte=ED done=%0d", d_done);
  endtask

  task automatic test_back_to_back();
    check_frame("b2b_ed", 8'hED, 0);
    check_frame("b2b_01", 8'h01, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      logic [7:0] b;
      int mode;
      b    = 8'($urandom);
      mode = int'($urandom_range(0, 1));
      check_frame("rand", b, mode);
    end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_hold_valid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
